// File: rtl/dma_pkg.sv
// dma_pkg
// Shared definitions for the word-copy DMA engine: FSM state encoding,
// default word size and the address-alignment mask helper.
package dma_pkg;

  localparam int DMA_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  // Mask that clears the byte-offset bits of a word address.
  function automatic logic [31:0] dma_align_mask(input int word_bytes);
    return ~((32'd1 << $clog2(word_bytes)) - 32'd1);
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen
// Source/destination pointer and remaining-word counter for the copy engine.
// On load it aligns both addresses, picks the copy direction (descending when
// the destination starts inside the source range, so overlapping data is not
// clobbered before it is read) and presets the pointers to the first word to
// move. Each step moves both pointers one word and consumes one word.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_load                latch i_src_addr/i_dst_addr/i_word_count
//   i_step                advance pointers and decrement the count
//   o_src_ptr, o_dst_ptr  current word pointers (byte addresses)
//   o_last_word           the word being moved now is the final one
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int WORD_BYTES = DMA_WORD_BYTES,
  parameter int COUNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [31:0]        i_src_addr,
  input  logic [31:0]        i_dst_addr,
  input  logic [COUNT_W-1:0] i_word_count,
  output logic [31:0]        o_src_ptr,
  output logic [31:0]        o_dst_ptr,
  output logic               o_last_word
);

  localparam logic [31:0] STEP       = 32'(WORD_BYTES);
  localparam logic [31:0] ALIGN_MASK = dma_align_mask(WORD_BYTES);
  // Wide enough that src + WORD_BYTES*N can never overflow.
  localparam int          SPAN_W     = COUNT_W + 33;

  logic [31:0]        w_src_al;
  logic [31:0]        w_dst_al;
  logic [SPAN_W-1:0]  w_span;
  logic [SPAN_W-1:0]  w_src_end;
  logic [31:0]        w_last_off;
  logic               w_desc;
  logic [31:0]        w_src_start;
  logic [31:0]        w_dst_start;

  logic [31:0]        r_src_ptr;
  logic [31:0]        r_dst_ptr;
  logic [COUNT_W-1:0] r_count;
  logic               r_desc;

  // Alignment, overlap detection and starting pointers for a new copy.
  always_comb begin
    w_src_al   = i_src_addr & ALIGN_MASK;
    w_dst_al   = i_dst_addr & ALIGN_MASK;
    w_span     = SPAN_W'(STEP) * SPAN_W'(i_word_count);
    w_src_end  = SPAN_W'(w_src_al) + w_span;
    w_desc     = (w_dst_al > w_src_al) && (SPAN_W'(w_dst_al) < w_src_end);
    // Offset of the last word; wraps modulo 2^32 like the pointers do.
    w_last_off = w_span[31:0] - STEP;
    if (w_desc) begin
      w_src_start = w_src_al + w_last_off;
      w_dst_start = w_dst_al + w_last_off;
    end else begin
      w_src_start = w_src_al;
      w_dst_start = w_dst_al;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_src_ptr <= 32'd0;
      r_dst_ptr <= 32'd0;
      r_count   <= '0;
      r_desc    <= 1'b0;
    end else if (i_load) begin
      r_src_ptr <= w_src_start;
      r_dst_ptr <= w_dst_start;
      r_count   <= i_word_count;
      r_desc    <= w_desc;
    end else if (i_step) begin
      if (r_desc) begin
        r_src_ptr <= r_src_ptr - STEP;
        r_dst_ptr <= r_dst_ptr - STEP;
      end else begin
        r_src_ptr <= r_src_ptr + STEP;
        r_dst_ptr <= r_dst_ptr + STEP;
      end
      r_count <= r_count - COUNT_W'(1'b1);
    end
  end

  assign o_src_ptr   = r_src_ptr;
  assign o_dst_ptr   = r_dst_ptr;
  assign o_last_word = (r_count == COUNT_W'(1'b1));

endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine
// Copies WordCount words from SrcAddr to DstAddr through a single-port data
// memory, one READ cycle and one WRITE cycle per word, overlap-safe.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start                   request pulse, only honoured in IDLE
//   i_src_addr, i_dst_addr    first-word byte addresses
//   i_word_count              number of words (0 -> immediate Done)
//   o_busy, o_done            copy in progress / one-cycle completion pulse
//   o_address, o_write_data   memory address and write data
//   o_mem_read, o_mem_write   memory strobes (never both high)
//   i_read_data               combinational read data from memory
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int WORD_BYTES = DMA_WORD_BYTES,
  parameter int COUNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [31:0]        i_src_addr,
  input  logic [31:0]        i_dst_addr,
  input  logic [COUNT_W-1:0] i_word_count,
  output logic               o_busy,
  output logic               o_done,
  output logic [31:0]        o_address,
  output logic [31:0]        o_write_data,
  output logic               o_mem_read,
  output logic               o_mem_write,
  input  logic [31:0]        i_read_data
);

  dma_state_e  r_state;
  dma_state_e  w_next_state;
  logic        w_load;
  logic        w_step;
  logic [31:0] r_buffer;
  logic [31:0] w_src_ptr;
  logic [31:0] w_dst_ptr;
  logic        w_last_word;

  dma_addr_gen #(
    .WORD_BYTES (WORD_BYTES),
    .COUNT_W    (COUNT_W)
  ) u_addr_gen (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_src_addr   (i_src_addr),
    .i_dst_addr   (i_dst_addr),
    .i_word_count (i_word_count),
    .o_src_ptr    (w_src_ptr),
    .o_dst_ptr    (w_dst_ptr),
    .o_last_word  (w_last_word)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus load/step strobes for the pointer block.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          if (i_word_count != '0) begin
            w_next_state = ST_READ;
          end else begin
            w_next_state = ST_DONE;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        w_step = 1'b1;
        if (w_last_word) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_READ;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Word buffer: holds the word read in READ for the following WRITE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buffer <= 32'd0;
    end else if (r_state == ST_READ) begin
      r_buffer <= i_read_data;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_address    = 32'd0;
    o_write_data = 32'd0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    case (r_state)
      ST_READ: begin
        o_busy     = 1'b1;
        o_mem_read = 1'b1;
        o_address  = w_src_ptr;
      end
      ST_WRITE: begin
        o_busy       = 1'b1;
        o_mem_write  = 1'b1;
        o_address    = w_dst_ptr;
        o_write_data = r_buffer;
      end
      ST_DONE: begin
        o_done = 1'b1;
      end
      ST_IDLE: begin
        o_done = 1'b0;
      end
      default: begin
        o_done = 1'b0;
      end
    endcase
  end

endmodule
